// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types and helpers for the fetch-side branch predictor.
//            Holds 2-bit counter encodings, the table entry struct, a
//            saturating counter update and the tag extraction helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // The tag field is sized for the narrowest possible index so the struct
  // does not depend on the module parameter; unused upper bits stay zero.
  localparam int unsigned TAG_FIELD_W = 30;

  typedef struct packed {
    logic                   valid;
    logic [TAG_FIELD_W-1:0] tag;
    logic [1:0]             ctr;
    logic [31:0]            target;
  } bp_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (ctr == ST)  ? ST  : ctr + 2'd1;
    else       nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
    return nxt;
  endfunction

  // word_addr is pc[31:2]; dropping the index bits leaves pc[31:IDX_W+2].
  function automatic logic [TAG_FIELD_W-1:0] pc_tag(input logic [29:0] word_addr,
                                                    input int unsigned idx_w);
    return word_addr >> idx_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter2
// Purpose  : Next-state logic of a 2-bit saturating taken/not-taken counter.
// Ports    : ctr      in  2  current counter value
//            taken    in  1  resolved branch outcome
//            ctr_next out 2  saturated next value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  assign ctr_next = sat_update(ctr, taken);

endmodule
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_predictor
// Purpose  : Direct-mapped branch target predictor for the fetch stage.
//            Combinational lookup by fetch PC; table written back by decode.
//            Optional macro GSHARE_EN xors a global history register into
//            the lookup index.
// Ports    : clk, rst_n (async active-low), clr (sync clear)
//            lookup_pc  -> pred_hit, pred_taken, pred_target, pred_idx
//            upd_valid, upd_idx, upd_pc, upd_is_branch, upd_taken, upd_target
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned GHR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [31:0]      upd_pc,
  input  logic             upd_is_branch,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             clr
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  bp_entry_t        entries_q [ENTRIES];
  logic [IDX_W-1:0] hist_idx;

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ghr_q <= '0;
    else if (clr)                        ghr_q <= '0;
    else if (upd_valid && upd_is_branch) ghr_q <= {ghr_q[GHR_W-2:0], upd_taken};
  end

  assign hist_idx = IDX_W'(ghr_q);
`else
  // Without history the xor term is a constant zero and folds away.
  logic [GHR_W-1:0] ghr_none;
  assign ghr_none = '0;
  assign hist_idx = IDX_W'(ghr_none);
`endif

  // ---------------------------------------------------------------- lookup
  bp_entry_t look_e;

  assign pred_idx    = lookup_pc[IDX_W+1:2] ^ hist_idx;
  assign look_e      = entries_q[pred_idx];
  assign pred_hit    = look_e.valid && (look_e.tag == pc_tag(lookup_pc[31:2], IDX_W));
  assign pred_taken  = pred_hit && look_e.ctr[1];
  assign pred_target = pred_hit ? look_e.target : 32'd0;

  // ---------------------------------------------------------------- update
  bp_entry_t  upd_e;
  bp_entry_t  wr_e;
  logic       upd_hit;
  logic       wr_en;
  logic [1:0] ctr_next;

  assign upd_e   = entries_q[upd_idx];
  assign upd_hit = upd_e.valid && (upd_e.tag == pc_tag(upd_pc[31:2], IDX_W));

  sat_counter2 u_ctr (
    .ctr      (upd_e.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    wr_en = 1'b0;
    wr_e  = upd_e;
    if (upd_is_branch) begin
      if (upd_hit) begin
        wr_en   = 1'b1;
        wr_e.ctr = ctr_next;
        if (upd_taken) wr_e.target = upd_target;
      end else if (upd_taken) begin
        // Fresh allocation starts weakly taken.
        wr_en       = 1'b1;
        wr_e.valid  = 1'b1;
        wr_e.tag    = pc_tag(upd_pc[31:2], IDX_W);
        wr_e.ctr    = WT;
        wr_e.target = upd_target;
      end
    end else if (upd_hit) begin
      // A non-branch matched the tag: the entry is a stale alias.
      wr_en      = 1'b1;
      wr_e.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid  <= 1'b0;
        entries_q[i].tag    <= '0;
        entries_q[i].ctr    <= WNT;
        entries_q[i].target <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
    end else if (upd_valid && wr_en) begin
      entries_q[upd_idx] <= wr_e;
    end
  end

  // Byte-offset bits carry no information for word-aligned instructions.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_predictor
// Purpose  : Self-checking bench for branch_target_predictor with a
//            behavioural reference table and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

  localparam int IDX_W = 6;
  localparam int GHR_W = 6;
  localparam int ENT   = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      lookup_pc;
  logic             pred_hit, pred_taken;
  logic [31:0]      pred_target;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid, upd_is_branch, upd_taken, clr;
  logic [IDX_W-1:0] upd_idx;
  logic [31:0]      upd_pc, upd_target;

  branch_target_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W)) dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_idx(pred_idx), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
    .upd_target(upd_target), .clr(clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [39:0] obs;
  assign obs = {pred_hit, pred_taken, pred_target, pred_idx};

  // Reference table
  bit          mv   [ENT];
  int unsigned mtag [ENT];
  int unsigned mctr [ENT];
  logic [31:0] mtgt [ENT];
  int unsigned mghr;

  function automatic int unsigned m_index(input logic [31:0] pc);
    return ((pc >> 2) % ENT) ^ mghr;
  endfunction

  function automatic logic [39:0] m_pred(input logic [31:0] pc);
    int unsigned i;
    bit h;
    i = m_index(pc);
    h = mv[i] && (mtag[i] == int'(pc >> 8));
    return {h, h && (mctr[i] >= 2), h ? mtgt[i] : 32'd0, 6'(i)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin mv[i] = 0; mctr[i] = 1; mtag[i] = 0; mtgt[i] = 0; end
    mghr = 0;
  endtask

  task automatic model_clr();
    for (int i = 0; i < ENT; i++) mv[i] = 0;
    mghr = 0;
  endtask

  task automatic model_update(input int unsigned i, input logic [31:0] pc,
                              input bit br, input bit tk, input logic [31:0] tgt);
    bit hit;
    hit = mv[i] && (mtag[i] == int'(pc >> 8));
    if (br) begin
      if (hit) begin
        if (tk) begin
          if (mctr[i] < 3) mctr[i]++;
          mtgt[i] = tgt;
        end else if (mctr[i] > 0) mctr[i]--;
      end else if (tk) begin
        mv[i] = 1; mtag[i] = pc >> 8; mctr[i] = 2; mtgt[i] = tgt;
      end
`ifdef GSHARE_EN
      mghr = ((mghr << 1) | int'(tk)) % ENT;
`endif
    end else if (hit) mv[i] = 0;
  endtask

  task automatic drive_update(input logic [31:0] pc, input bit br, input bit tk,
                              input logic [31:0] tgt);
    int unsigned i;
    @(negedge clk);
    i = m_index(pc);
    upd_valid = 1; upd_pc = pc; upd_idx = 6'(i);
    upd_is_branch = br; upd_taken = tk; upd_target = tgt;
    @(posedge clk);
    model_update(i, pc, br, tk, tgt);
    #1 upd_valid = 0;
  endtask

  task automatic test_reset();
    lookup_pc = 32'h0040_0010;
    #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd4}) begin errors++; $display("FAIL reset_lookup: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd4}); end
    @(posedge clk); #1 rst_n = 1;
    #1;
    checks++; if (obs !== m_pred(lookup_pc)) begin errors++; $display("FAIL reset_release: got %h want %h", obs, m_pred(lookup_pc)); end
  endtask

  task automatic test_alloc_and_train();
    drive_update(32'h0040_0010, 1, 1, 32'h0040_0040);
    lookup_pc = 32'h0040_0010; #1;
    checks++; if (obs !== {1'b1, 1'b1, 32'h0040_0040, 6'd4}) begin errors++; $display("FAIL alloc_hit: got %h want %h", obs, {1'b1, 1'b1, 32'h0040_0040, 6'd4}); end
    drive_update(32'h0040_0010, 1, 0, 32'h0);
    lookup_pc = 32'h0040_0010; #1;
    checks++; if (obs !== {1'b1, 1'b0, 32'h0040_0040, 6'd4}) begin errors++; $display("FAIL weaken_nt: got %h want %h", obs, {1'b1, 1'b0, 32'h0040_0040, 6'd4}); end
  endtask

  task automatic test_saturation();
    drive_update(32'h0040_0020, 1, 1, 32'h0040_0100);
    for (int k = 0; k < 4; k++) drive_update(32'h0040_0020, 1, 1, 32'h0040_0100);
    lookup_pc = 32'h0040_0020; #1;
    checks++; if (obs !== {1'b1, 1'b1, 32'h0040_0100, 6'd8}) begin errors++; $display("FAIL sat_top: got %h want %h", obs, {1'b1, 1'b1, 32'h0040_0100, 6'd8}); end
    drive_update(32'h0040_0020, 1, 0, 32'h0);
    lookup_pc = 32'h0040_0020; #1;
    checks++; if (obs !== {1'b1, 1'b1, 32'h0040_0100, 6'd8}) begin errors++; $display("FAIL sat_one_nt: got %h want %h", obs, {1'b1, 1'b1, 32'h0040_0100, 6'd8}); end
    drive_update(32'h0040_0020, 1, 0, 32'h0);
    lookup_pc = 32'h0040_0020; #1;
    checks++; if (obs !== {1'b1, 1'b0, 32'h0040_0100, 6'd8}) begin errors++; $display("FAIL sat_two_nt: got %h want %h", obs, {1'b1, 1'b0, 32'h0040_0100, 6'd8}); end
    for (int k = 0; k < 3; k++) drive_update(32'h0040_0020, 1, 0, 32'h0);
    lookup_pc = 32'h0040_0020; #1;
    checks++; if (obs !== m_pred(32'h0040_0020) || pred_taken !== 1'b0) begin errors++; $display("FAIL sat_bottom: got %h want %h", obs, m_pred(32'h0040_0020)); end
    drive_update(32'h0040_0020, 1, 1, 32'h0040_0200);
    lookup_pc = 32'h0040_0020; #1;
    checks++; if (obs !== {1'b1, 1'b0, 32'h0040_0200, 6'd8}) begin errors++; $display("FAIL sat_retarget: got %h want %h", obs, {1'b1, 1'b0, 32'h0040_0200, 6'd8}); end
  endtask

  task automatic test_alias();
    drive_update(32'h0040_0110, 0, 0, 32'h0);
    lookup_pc = 32'h0040_0010; #1;
    checks++; if (obs !== {1'b1, 1'b0, 32'h0040_0040, 6'd4}) begin errors++; $display("FAIL alias_miss_kept: got %h want %h", obs, {1'b1, 1'b0, 32'h0040_0040, 6'd4}); end
    drive_update(32'h0040_0110, 1, 0, 32'h0);
    lookup_pc = 32'h0040_0110; #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd4}) begin errors++; $display("FAIL nt_miss_nowrite: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd4}); end
    drive_update(32'h0040_0010, 0, 0, 32'h0);
    lookup_pc = 32'h0040_0010; #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd4}) begin errors++; $display("FAIL alias_clear: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd4}); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    lookup_pc = 32'h0040_0030;
    upd_valid = 1; upd_pc = 32'h0040_0030; upd_idx = 6'(m_index(32'h0040_0030));
    upd_is_branch = 1; upd_taken = 1; upd_target = 32'h0040_0300;
    #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd12}) begin errors++; $display("FAIL same_cycle_old: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd12}); end
    @(posedge clk);
    model_update(12, 32'h0040_0030, 1, 1, 32'h0040_0300);
    #1 upd_valid = 0;
    #1;
    checks++; if (obs !== {1'b1, 1'b1, 32'h0040_0300, 6'd12}) begin errors++; $display("FAIL same_cycle_new: got %h want %h", obs, {1'b1, 1'b1, 32'h0040_0300, 6'd12}); end
  endtask

  task automatic test_clr();
    drive_update(32'h0040_0040, 1, 1, 32'h0040_0400);
    @(negedge clk);
    clr = 1;
    upd_valid = 1; upd_pc = 32'h0040_0050; upd_idx = 6'(m_index(32'h0040_0050));
    upd_is_branch = 1; upd_taken = 1; upd_target = 32'h0040_0500;
    @(posedge clk);
    model_clr();
    #1 begin clr = 0; upd_valid = 0; end
    lookup_pc = 32'h0040_0040; #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd16}) begin errors++; $display("FAIL clr_old_entry: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd16}); end
    lookup_pc = 32'h0040_0050; #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd20}) begin errors++; $display("FAIL clr_beats_update: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd20}); end
  endtask

  task automatic test_random();
    int unsigned i;
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      lookup_pc = 32'h0040_0000 | ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
      pc = 32'h0040_0000 | ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
      i = m_index(pc);
      upd_valid = ($urandom % 4) != 0; upd_pc = pc; upd_idx = 6'(i);
      upd_is_branch = ($urandom % 5) != 0; upd_taken = $urandom % 2;
      upd_target = $urandom & 32'hFFFF_FFFC;
      clr = ($urandom % 40) == 0;
      #1;
      checks++; if (obs !== m_pred(lookup_pc)) begin errors++; $display("FAIL random_%0d: got %h want %h", n, obs, m_pred(lookup_pc)); end
      @(posedge clk);
      if (clr) model_clr();
      else if (upd_valid) model_update(i, pc, upd_is_branch, upd_taken, upd_target);
    end
    #1 begin upd_valid = 0; clr = 0; end
  endtask

  task automatic test_async_reset();
    drive_update(32'h0040_0070, 1, 1, 32'h0040_0700);
    lookup_pc = 32'h0040_0070; #1;
    checks++; if (obs !== m_pred(lookup_pc) || pred_hit !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %h want %h", obs, m_pred(lookup_pc)); end
    @(posedge clk); #3 rst_n = 0;
    #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd28}) begin errors++; $display("FAIL async_reset: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd28}); end
    model_reset();
    #1 rst_n = 1;
    @(posedge clk); #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd28}) begin errors++; $display("FAIL post_reset: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd28}); end
  endtask

`ifdef GSHARE_EN
  task automatic test_gshare();
    for (int k = 0; k < 3; k++) drive_update(32'h0040_0200 + 32'(k * 4), 1, 1, 32'h0040_0800);
    lookup_pc = 32'h0040_0000; #1;
    checks++; if (pred_idx !== 6'd7) begin errors++; $display("FAIL gshare_idx: got %0d want 7", pred_idx); end
    @(posedge clk); #3 rst_n = 0;
    #1;
    checks++; if (obs !== {1'b0, 1'b0, 32'd0, 6'd0}) begin errors++; $display("FAIL gshare_reset: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 6'd0}); end
    model_reset();
    #1 rst_n = 1;
  endtask
`endif

  initial begin
    rst_n = 1; lookup_pc = '0; upd_valid = 0; upd_idx = '0; upd_pc = '0;
    upd_is_branch = 0; upd_taken = 0; upd_target = '0; clr = 0;
    model_reset();
    #2 rst_n = 0;
    test_reset();
    test_alloc_and_train();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_clr();
    test_random();
    test_async_reset();
`ifdef GSHARE_EN
    test_gshare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
